pll_lock_sequencer: RTL and testbench

Power-up and recovery controller for the board PLL chain (25 MHz pin clock -> 200 MHz -> 60/30 MHz). It runs on the free-running pin clock, drives the PLL reset, and qualifies the asynchronous `locked` indication. It holds the downstream system reset until lock has been stable, and re-sequences the PLL on timeout or lock loss. Retries are bounded, with a fault output when the limit is reached.

---
 rtl/pll_lock_sequencer.sv | 165 ++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: drives the PLL reset, qualifies the synchronized
// lock indication, releases the system reset once lock is stable, and bounds retries.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 25000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       clk_pin,
  input  logic       reset,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [3:0] retry_count
);

  localparam int CNT_MAX = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST    = TMO_W'(LOCK_TIMEOUT - 1);

  // A limit above 15 can never be matched by the saturating counter, so it retries forever.
  localparam bit         LIMITED     = (MAX_RETRIES != 0) && (MAX_RETRIES <= 15);
  localparam logic [3:0] RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [3:0]       retry_count_q, retry_count_d;
  logic             lock_lost_q, lock_lost_d;
  logic             pll_rst_q, pll_rst_d;
  logic             sys_rst_q, sys_rst_d;
  logic             ready_q, ready_d;
  logic             fault_q, fault_d;
  logic             sync_q, sync_d;
  logic             locked_s_q, locked_s_d;
  logic             timeout;

  always_comb begin
    sync_d        = locked;
    locked_s_d    = sync_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    retry_count_d = retry_count_q;
    lock_lost_d   = lock_lost_q;
    timeout       = ((state_q == WAIT_LOCK) || (state_q == STABLE)) && (tmo_q == TMO_LAST);

    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          tmo_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The first locked_s cycle seen here counts as the first qualified cycle,
      // so STABLE starts its count at 1.
      WAIT_LOCK: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (!timeout && locked_s_q) begin
          cnt_d   = CNT_W'(1);
          state_d = (STABLE_CYCLES == 1) ? RUN : STABLE;
        end
      end
      STABLE: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (!timeout) begin
          if (!locked_s_q) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RUN: begin
        if (!locked_s_q) begin
          state_d     = RESET_PLL;
          cnt_d       = '0;
          lock_lost_d = 1'b1;
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = RESET_PLL;
        cnt_d   = '0;
      end
    endcase

    // Timeout overrides any lock-driven transition taken above.
    if (timeout) begin
      cnt_d = '0;
      if (LIMITED && (retry_count_q == RETRY_LIMIT)) begin
        state_d = FAULT;
      end else begin
        state_d = RESET_PLL;
        if (retry_count_q != 4'hF) begin
          retry_count_d = retry_count_q + 4'd1;
        end
      end
    end

    pll_rst_d = (state_d == RESET_PLL) || (state_d == FAULT);
    sys_rst_d = (state_d != RUN);
    ready_d   = (state_d == RUN);
    fault_d   = (state_d == FAULT);
  end

  always_ff @(posedge clk_pin) begin
    if (reset) begin
      state_q       <= RESET_PLL;
      cnt_q         <= '0;
      tmo_q         <= '0;
      retry_count_q <= 4'd0;
      lock_lost_q   <= 1'b0;
      pll_rst_q     <= 1'b1;
      sys_rst_q     <= 1'b1;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
      sync_q        <= 1'b0;
      locked_s_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      retry_count_q <= retry_count_d;
      lock_lost_q   <= lock_lost_d;
      pll_rst_q     <= pll_rst_d;
      sys_rst_q     <= sys_rst_d;
      ready_q       <= ready_d;
      fault_q       <= fault_d;
      sync_q        <= sync_d;
      locked_s_q    <= locked_s_d;
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fault       = fault_q;
  assign lock_lost   = lock_lost_q;
  assign retry_count = retry_count_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer: directed scenarios with hand-computed
// checkpoints plus randomized lock patterns compared every cycle against a reference model.
module tb_pll_lock_sequencer;

  localparam int RST  = 4;
  localparam int TMO  = 100;
  localparam int STB  = 8;
  localparam int MAXR = 2;

  logic       clk_pin;
  logic       reset;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [3:0] retry_count;

  int checks;
  int errors;
  int cyc;
  bit model_valid;

  // Reference model: countdown of PLL-reset cycles, cycles since PLL release,
  // length of the current unbroken locked run, and flags for run/fault/lost.
  int m_rst_left;
  int m_since;
  int m_streak;
  int m_retry;
  bit m_run;
  bit m_fault;
  bit m_lost;
  bit m_s1;
  bit m_s2;

  pll_lock_sequencer #(
    .RST_CYCLES(RST),
    .LOCK_TIMEOUT(TMO),
    .STABLE_CYCLES(STB),
    .MAX_RETRIES(MAXR)
  ) dut (
    .clk_pin(clk_pin),
    .reset(reset),
    .locked(locked),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .fault(fault),
    .lock_lost(lock_lost),
    .retry_count(retry_count)
  );

  initial clk_pin = 1'b0;
  always #20 clk_pin = ~clk_pin;

  always @(posedge clk_pin) begin
    if (reset) begin
      m_rst_left  = RST;
      m_since     = 0;
      m_streak    = 0;
      m_retry     = 0;
      m_run       = 0;
      m_fault     = 0;
      m_lost      = 0;
      m_s1        = 0;
      m_s2        = 0;
      cyc         = 0;
      model_valid = 1;
    end else begin
      cyc++;
      if (m_fault) begin
        m_fault = 1;
      end else if (m_rst_left > 0) begin
        m_rst_left--;
        if (m_rst_left == 0) begin
          m_since  = 0;
          m_streak = 0;
        end
      end else if (m_run) begin
        if (!m_s2) begin
          m_run      = 0;
          m_lost     = 1;
          m_rst_left = RST;
        end
      end else if (m_since == TMO - 1) begin
        if (MAXR != 0 && m_retry == MAXR) begin
          m_fault = 1;
        end else begin
          if (m_retry < 15) m_retry++;
          m_rst_left = RST;
        end
      end else begin
        m_streak = m_s2 ? m_streak + 1 : 0;
        if (m_streak == STB) m_run = 1;
        m_since++;
      end
      m_s2 = m_s1;
      m_s1 = locked;
    end
  end

  always @(negedge clk_pin) begin
    logic [8:0] exp_v;
    logic [8:0] act_v;
    if (model_valid) begin
      exp_v = {m_fault || (m_rst_left > 0), !m_run, m_run, m_fault, m_lost, 4'(m_retry)};
      act_v = {pll_rst, sys_rst, ready, fault, lock_lost, retry_count};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("[TB] FAIL cycle_cmp at cyc %0d: got %b expected %b (pll_rst,sys_rst,ready,fault,lock_lost,retry)",
                 cyc, act_v, exp_v);
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit lk);
    reset  = rst;
    locked = lk;
  endtask

  task automatic applyReset();
    applyStimulus(1'b1, 1'b0);
    repeat (2) @(negedge clk_pin);
    reset = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk_pin);
    reset = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    int budget;
    budget = 2000;
    while (cyc < c && budget > 0) begin
      @(negedge clk_pin);
      budget--;
    end
    if (cyc != c) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_cycle: got cyc %0d expected %0d", cyc, c);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_pll_rst"}, pll_rst, 1);
    checkOutput({tag, "_sys_rst"}, sys_rst, 1);
    checkOutput({tag, "_ready"}, ready, 0);
    checkOutput({tag, "_fault"}, fault, 0);
    checkOutput({tag, "_lock_lost"}, lock_lost, 0);
    checkOutput({tag, "_retry"}, retry_count, 0);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    model_valid = 0;
    applyStimulus(1'b1, 1'b0);

    $display("[TB] clean start and lock loss in RUN");
    applyReset();
    checkResetValues("start");
    waitUntil(3);
    checkOutput("s1_pll_rst_c3", pll_rst, 1);
    waitUntil(4);
    checkOutput("s1_pll_rst_c4", pll_rst, 0);
    waitUntil(10);
    locked = 1'b1;
    waitUntil(19);
    checkOutput("s1_sys_rst_c19", sys_rst, 1);
    checkOutput("s1_ready_c19", ready, 0);
    waitUntil(20);
    checkOutput("s1_sys_rst_c20", sys_rst, 0);
    checkOutput("s1_ready_c20", ready, 1);
    checkOutput("s1_retry", retry_count, 0);
    checkOutput("s1_lock_lost", lock_lost, 0);
    waitUntil(30);
    locked = 1'b0;
    waitUntil(32);
    checkOutput("s4_ready_c32", ready, 1);
    waitUntil(33);
    locked = 1'b1;
    checkOutput("s4_ready_c33", ready, 0);
    checkOutput("s4_sys_rst_c33", sys_rst, 1);
    checkOutput("s4_lock_lost_c33", lock_lost, 1);
    checkOutput("s4_pll_rst_c33", pll_rst, 1);
    checkOutput("s4_retry_c33", retry_count, 0);
    waitUntil(36);
    checkOutput("s4_pll_rst_c36", pll_rst, 1);
    waitUntil(37);
    checkOutput("s4_pll_rst_c37", pll_rst, 0);
    waitUntil(44);
    checkOutput("s4_ready_c44", ready, 0);
    waitUntil(45);
    checkOutput("s4_ready_c45", ready, 1);
    checkOutput("s4_lock_lost_c45", lock_lost, 1);
    waitUntil(50);
    pulseReset();
    checkResetValues("run_reset");

    $display("[TB] flapping lock");
    applyReset();
    while (cyc < 112) begin
      locked = (cyc >= 8) && ((((cyc - 8) / 5) % 2) == 0);
      if (cyc == 103) checkOutput("s2_retry_c103", retry_count, 0);
      if (cyc == 104) begin
        checkOutput("s2_retry_c104", retry_count, 1);
        checkOutput("s2_pll_rst_c104", pll_rst, 1);
      end
      if (cyc == 107) checkOutput("s2_pll_rst_c107", pll_rst, 1);
      if (cyc == 108) checkOutput("s2_pll_rst_c108", pll_rst, 0);
      @(negedge clk_pin);
    end

    $display("[TB] timeout priority");
    applyReset();
    waitUntil(101);
    locked = 1'b1;
    waitUntil(103);
    checkOutput("s5_pll_rst_c103", pll_rst, 0);
    waitUntil(104);
    checkOutput("s5_pll_rst_c104", pll_rst, 1);
    checkOutput("s5_retry_c104", retry_count, 1);
    checkOutput("s5_ready_c104", ready, 0);
    waitUntil(115);
    checkOutput("s5_ready_c115", ready, 0);
    waitUntil(116);
    checkOutput("s5_ready_c116", ready, 1);
    checkOutput("s5_retry_c116", retry_count, 1);

    $display("[TB] never lock and reset from FAULT");
    applyReset();
    waitUntil(104);
    checkOutput("s3_retry_c104", retry_count, 1);
    waitUntil(208);
    checkOutput("s3_retry_c208", retry_count, 2);
    waitUntil(311);
    checkOutput("s3_fault_c311", fault, 0);
    waitUntil(312);
    checkOutput("s3_fault_c312", fault, 1);
    checkOutput("s3_pll_rst_c312", pll_rst, 1);
    checkOutput("s3_sys_rst_c312", sys_rst, 1);
    checkOutput("s3_retry_c312", retry_count, 2);
    waitUntil(400);
    checkOutput("s3_fault_c400", fault, 1);
    pulseReset();
    checkResetValues("fault_reset");
    waitUntil(10);
    locked = 1'b1;
    waitUntil(20);
    checkOutput("s6_ready_c20", ready, 1);

    $display("[TB] randomized lock patterns");
    for (int ep = 0; ep < 6; ep++) begin
      applyReset();
      for (int s = 0; s < 60; s++) begin : seg_blk
        bit lk;
        int len;
        if ($urandom_range(0, 99) < 70) begin
          lk  = 1'b1;
          len = int'($urandom_range(1, 40));
        end else begin
          lk  = 1'b0;
          len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 60)) : int'($urandom_range(1, 3));
        end
        if ($urandom_range(0, 49) == 0) pulseReset();
        locked = lk;
        repeat (len) @(negedge clk_pin);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(40 * 200000);
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
